fetch_unit: RTL and testbench

Instruction fetch front end for the RISC-V core. It owns the PC, issues word reads to instruction memory with a ready handshake, and presents the fetched word to the Control decoder and datapath. On acceptance it computes the next PC from the decoder's OrigPC selection, the ALU zero flag and the immediate.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_next_pc.sv | 18 +
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: encodings shared by the fetch front end and Control.
// Holds next-PC select codes, the NOP word, the fetch FSM states and TRUE/FALSE.
package fetch_unit_pkg;
  localparam logic [1:0] PC4 = 2'b00;
  localparam logic [1:0] PCBEQ = 2'b01;
  localparam logic [1:0] PCIMM = 2'b10;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_e;
endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection for the fetch unit.
// Ports: pc_i, orig_pc_i, alu_zero_i, imm_i in; next_pc_o (raw 32-bit modular sum), misaligned_o out.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  orig_pc_i,
  input  logic        alu_zero_i,
  input  logic [31:0] imm_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);
  logic use_imm;
  // 2'b11 falls through to the sequential pc+4 path.
  assign use_imm = (orig_pc_i == PCIMM) || ((orig_pc_i == PCBEQ) && alu_zero_i);
  assign next_pc_o = pc_i + (use_imm ? imm_i : 32'd4);
  assign misaligned_o = next_pc_o[1:0] != 2'b00;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM owning the PC, with ready-handshaked word reads.
// Ports: clock/reset; imem_req/imem_addr/imem_ready/imem_rdata to instruction memory;
// instruction/pc/instr_valid/instr_ack to the decoder; orig_pc/alu_zero/imm pick the next PC;
// fetch_fault flags a misaligned target. Optional macro MISALIGN_TRAP_EN: misaligned target traps
// into a sticky FAULT state; otherwise the target is word-aligned and fetch_fault stays 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = fetch_unit_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic [1:0]  orig_pc,
  input  logic        alu_zero,
  input  logic [31:0] imm,
  output logic        fetch_fault
);
  import fetch_unit_pkg::*;
`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = TRUE;
`else
  localparam logic TRAP_EN = FALSE;
`endif
  state_e state_q;
  logic [31:0] pc_q, instr_q, raw_pc, pc_d;
  logic req_q, valid_q, fault_q, misaligned, trap;
  next_pc_calc u_next_pc (
    .pc_i(pc_q),
    .orig_pc_i(orig_pc),
    .alu_zero_i(alu_zero),
    .imm_i(imm),
    .next_pc_o(raw_pc),
    .misaligned_o(misaligned)
  );
  assign trap = TRAP_EN && misaligned;
  assign pc_d = TRAP_EN ? raw_pc : {raw_pc[31:2], 2'b00};
  // req_q stays low for one cycle after reset so a stale ready from an abandoned request is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= NOP_WORD;
      req_q <= FALSE;
      valid_q <= FALSE;
      fault_q <= FALSE;
    end else begin
      case (state_q)
        FETCH:
          if (!req_q) req_q <= TRUE;
          else if (imem_ready) begin
            instr_q <= imem_rdata;
            req_q <= FALSE;
            valid_q <= TRUE;
            state_q <= HOLD;
          end
        HOLD:
          if (instr_ack) begin
            valid_q <= FALSE;
            instr_q <= NOP_WORD;
            if (trap) begin
              fault_q <= TRUE;
              state_q <= FAULT;
            end else begin
              pc_q <= pc_d;
              req_q <= TRUE;
              state_q <= FETCH;
            end
          end
        default: ;
      endcase
    end
  end
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_fault = TRAP_EN && fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  logic clock = 1'b0, reset = 1'b1, imem_ready = 1'b0, instr_ack = 1'b0, alu_zero = 1'b0;
  logic imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, instruction, pc, imm = 32'h0;
  logic [1:0] orig_pc = 2'b00;
  int n_cmp = 0, n_bad = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .orig_pc(orig_pc), .alu_zero(alu_zero),
    .imm(imm), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;
  assign imem_rdata = {8'hC3, imem_addr[23:0]};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input logic [1:0] o, input logic z, input logic [31:0] im);
    orig_pc = o; alu_zero = z; imm = im; imem_ready = 1'b1; instr_ack = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_ready = 1'b1; instr_ack = 1'b1;
    tick;
    reset = 1'b0;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_cmp++; if (instruction !== 32'h13) begin n_bad++; $display("FAIL reset_instr got %h want %h", instruction, 32'h13); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    orig_pc = 2'b00; imem_ready = 1'b1; instr_ack = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_bad++; $display("FAIL seq_req req %b addr %h want 1 %h", imem_req, imem_addr, a); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL seq_valid_lo got %b want 0", instr_valid); end
      tick;
      n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL seq_valid_hi valid %b req %b want 1 0", instr_valid, imem_req); end
      n_cmp++; if (instruction !== {8'hC3, a[23:0]} || pc !== a) begin n_bad++; $display("FAIL seq_word instr %h pc %h want %h %h", instruction, pc, {8'hC3, a[23:0]}, a); end
      tick;
    end
  endtask

  task automatic test_branch;
    retire(2'b01, 1'b1, 32'hFFFF_FFF8);
    n_cmp++; if (imem_addr !== 32'h08) begin n_bad++; $display("FAIL beq_taken got %h want %h", imem_addr, 32'h08); end
    retire(2'b10, 1'b0, 32'h8);
    n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL jmp_fwd got %h want %h", imem_addr, 32'h10); end
    retire(2'b01, 1'b0, 32'hFFFF_FFF8);
    n_cmp++; if (imem_addr !== 32'h14) begin n_bad++; $display("FAIL beq_not_taken got %h want %h", imem_addr, 32'h14); end
  endtask

  task automatic test_wrap;
    retire(2'b10, 1'b0, 32'hFFFF_FFE8);
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL jmp_back got %h want %h", imem_addr, 32'hFFFF_FFFC); end
    retire(2'b00, 1'b0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap got %h want %h", imem_addr, 32'h0); end
    retire(2'b11, 1'b1, 32'h40);
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL sel11 got %h want %h", imem_addr, 32'h4); end
    retire(2'b10, 1'b0, 32'h1C);
    retire(2'b10, 1'b0, 32'h100);
    n_cmp++; if (imem_addr !== 32'h120) begin n_bad++; $display("FAIL pcimm got %h want %h", imem_addr, 32'h120); end
  endtask

  task automatic test_wait;
    imem_ready = 1'b0; instr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h120 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL wait req %b addr %h valid %b want 1 120 0", imem_req, imem_addr, instr_valid); end
    end
    imem_ready = 1'b1; instr_ack = 1'b0;
    tick;
    n_cmp++; if (instr_valid !== 1'b1 || instruction !== 32'hC300_0120) begin n_bad++; $display("FAIL wait_capture valid %b instr %h want 1 c3000120", instr_valid, instruction); end
  endtask

  task automatic test_hold;
    instr_ack = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h120 || instruction !== 32'hC300_0120 || imem_req !== 1'b0) begin n_bad++; $display("FAIL hold valid %b pc %h instr %h req %b", instr_valid, pc, instruction, imem_req); end
    end
    orig_pc = 2'b00; instr_ack = 1'b1;
    tick;
    n_cmp++; if (imem_addr !== 32'h124 || imem_req !== 1'b1 || instr_valid !== 1'b0 || instruction !== 32'h13) begin n_bad++; $display("FAIL hold_release addr %h req %b valid %b instr %h", imem_addr, imem_req, instr_valid, instruction); end
  endtask

  task automatic test_reset_mid;
    imem_ready = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; imem_ready = 1'b1; instr_ack = 1'b0;
    n_cmp++; if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_reset pc %h valid %b req %b want 0 0 0", pc, instr_valid, imem_req); end
    tick;
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL stale_ready valid %b req %b addr %h want 0 1 0", instr_valid, imem_req, imem_addr); end
    tick;
    n_cmp++; if (instr_valid !== 1'b1 || instruction !== 32'hC300_0000) begin n_bad++; $display("FAIL post_reset_fetch valid %b instr %h want 1 c3000000", instr_valid, instruction); end
  endtask

  task automatic test_misalign;
    orig_pc = 2'b10; imm = 32'h40; instr_ack = 1'b1;
    tick;
    n_cmp++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL to_40 got %h want %h", imem_addr, 32'h40); end
    retire(2'b10, 1'b0, 32'h2);
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40) begin n_bad++; $display("FAIL trap fault %b req %b valid %b pc %h", fetch_fault, imem_req, instr_valid, pc); end
      tick;
    end
`else
    n_cmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || fetch_fault !== 1'b0) begin n_bad++; $display("FAIL align addr %h req %b fault %b want 40 1 0", imem_addr, imem_req, fetch_fault); end
`endif
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_branch;
    test_wrap;
    test_wait;
    test_hold;
    test_reset_mid;
    test_misalign;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
